// File: rtl/fp_mul_arbiter_if.sv
// Bundle of requester-side and multiplier-side signals of the shared FP32 multiplier arbiter.
// The slave modport is the arbiter; the master modport is its environment (requesters + multiplier).
interface fp_mul_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IW   = 2
);
  logic [NREQ-1:0]    req;
  logic [32*NREQ-1:0] op1_bus;
  logic [32*NREQ-1:0] op2_bus;
  logic [NREQ-1:0]    ack;
  logic [31:0]        res_out;
  logic               err_out;
  logic               busy;
  logic [IW-1:0]      gnt_idx;
  logic               mul_ready;
  logic [31:0]        mul_op1;
  logic [31:0]        mul_op2;
  logic [31:0]        mul_res;
  logic               mul_done;

  modport slave (
    input  req, op1_bus, op2_bus, mul_res, mul_done,
    output ack, res_out, err_out, busy, gnt_idx, mul_ready, mul_op1, mul_op2
  );

  modport master (
    output req, op1_bus, op2_bus, mul_res, mul_done,
    input  ack, res_out, err_out, busy, gnt_idx, mul_ready, mul_op1, mul_op2
  );
endinterface

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one single-precision multiplier among NREQ requesters,
// with operand latching, a start strobe, a done watchdog and a one-cycle ack per transaction.
module fp_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64,
  parameter int IW      = 2
) (
  input logic            clk,
  input logic            rst,
  fp_mul_arbiter_if.slave bus
);

  localparam int NPAD = 1 << IW;
  localparam int WDW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW:0]     NREQ_W      = (IW+1)'(NREQ);
  localparam logic [WDW-1:0]  WDOG_LAST   = WDW'(TIMEOUT - 1);
  localparam logic [31:0]     TIMEOUT_RES = 32'h7FFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   gnt_q;
  logic [IW-1:0]   rr_idx;
  logic            rr_hit;
  logic [31:0]     sel_op1, sel_op2;
  logic [31:0]     op1_q, op2_q;
  logic [31:0]     res_q;
  logic            err_q;
  logic [WDW-1:0]  wdog;
  logic            wdog_exp;
  logic [NPAD-1:0] req_pad;
  logic [NPAD-1:0] ack_pad;
  logic [IW:0]     cand;

  assign wdog_exp = (wdog == WDOG_LAST);

  // Round-robin search starting one past the last served requester.
  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    req_pad            = '0;
    req_pad[NREQ-1:0]  = bus.req;
    rr_idx             = last_grant;
    rr_hit             = 1'b0;
    cand               = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = {1'b0, last_grant} + (IW+1)'(i);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!rr_hit && req_pad[cand[IW-1:0]]) begin
        rr_hit = 1'b1;
        rr_idx = cand[IW-1:0];
      end
    end
  end

  // Operand mux for the round-robin winner.
  always_comb begin
    sel_op1 = '0;
    sel_op2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rr_idx == IW'(i)) begin
        sel_op1 = bus.op1_bus[i*32 +: 32];
        sel_op2 = bus.op2_bus[i*32 +: 32];
      end
    end
  end

  // NOTE: state-holding registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ack_pad   = '0;
    unique case (state)
      IDLE:  if (rr_hit) state_nxt = SETUP;
      SETUP: state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (bus.mul_done || wdog_exp) state_nxt = RESP;
      RESP: begin
        ack_pad[gnt_q] = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ack       = ack_pad[NREQ-1:0];
  assign bus.busy      = (state != IDLE);
  assign bus.mul_ready = (state == ISSUE);
  assign bus.mul_op1   = op1_q;
  assign bus.mul_op2   = op2_q;
  assign bus.res_out   = res_q;
  assign bus.err_out   = err_q;
  assign bus.gnt_idx   = gnt_q;

  // Datapath: grant capture, watchdog, result capture and round-robin pointer.
  // NOTE: these are a handful of discrete registers, not a memory, so all of them take the async reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= IW'(NREQ - 1);
      gnt_q      <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      res_q      <= '0;
      err_q      <= 1'b0;
      wdog       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rr_hit) begin
            gnt_q <= rr_idx;
            op1_q <= sel_op1;
            op2_q <= sel_op2;
          end
        end
        ISSUE: wdog <= '0;
        WAIT: begin
          if (bus.mul_done) begin
            res_q <= bus.mul_res;
            err_q <= 1'b0;
          end else if (wdog_exp) begin
            res_q <= TIMEOUT_RES;
            err_q <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RESP: last_grant <= gnt_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Self-checking bench for fp_mul_arbiter: behavioural FP32 multiplier, scoreboard of expected acks,
// table-driven single transactions plus round-robin, drop, operand-hold, timeout and reset sequences.
module tb_fp_mul_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;
  localparam int IW      = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp_mul_arbiter_if #(.NREQ(NREQ), .IW(IW)) bus ();

  fp_mul_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .IW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference FP32 multiply (normals, round-to-nearest-even, denormals flushed to zero).
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          e;
    logic [47:0] p;
    logic [22:0] frac;
    logic        g, st;
    logic [24:0] m;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'b0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      frac = p[46:24]; g = p[23]; st = |p[22:0]; e++;
    end else begin
      frac = p[45:23]; g = p[22]; st = |p[21:0];
    end
    m = {2'b01, frac} + 25'(g && (st || frac[0]));
    if (m[24]) begin e++; frac = m[23:1]; end
    else       frac = m[22:0];
    if (e >= 255) return {s, 8'hFF, 23'b0};
    if (e <= 0)   return {s, 31'b0};
    return {s, e[7:0], frac};
  endfunction

  // Multiplier model: captures operands on the start strobe, answers mul_lat cycles later.
  int          mul_lat = 1;
  bit          stub    = 1'b0;
  int          cnt;
  logic [31:0] pend;
  logic        model_done;
  logic        stray_done = 1'b0;

  assign bus.mul_done = model_done | stray_done;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= 0;
      pend        <= '0;
      model_done  <= 1'b0;
      bus.mul_res <= '0;
    end else begin
      model_done <= 1'b0;
      if (bus.mul_ready) begin
        pend <= fp_mul(bus.mul_op1, bus.mul_op2);
        cnt  <= stub ? 0 : mul_lat;
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          model_done  <= 1'b1;
          bus.mul_res <= pend;
        end
      end
    end
  end

  // Scoreboard: expectations pushed when stimulus is driven, popped on each ack.
  typedef struct {
    int          idx;
    logic [31:0] res;
    logic        err;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (bus.ack !== '0) begin
      check("ack_onehot", $countones(bus.ack), 1);
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'(bus.ack), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_vector", 32'(bus.ack), 32'(1 << e.idx));
        check("res_out",    bus.res_out, e.res);
        check("err_out",    32'(bus.err_out), 32'(e.err));
        check("gnt_idx",    32'(bus.gnt_idx), 32'(e.idx));
      end
    end
  end

  task automatic wait_ack(input int limit, output int at_cyc);
    bit seen = 1'b0;
    at_cyc = -1;
    for (int k = 0; k < limit && !seen; k++) begin
      @(negedge clk);
      if (bus.ack !== '0) begin
        seen   = 1'b1;
        at_cyc = cyc;
      end
    end
    check("ack_within_bound", 32'(seen), 32'd1);
  endtask

  task automatic wait_ready(input int limit, output int at_cyc);
    bit seen = 1'b0;
    at_cyc = -1;
    for (int k = 0; k < limit && !seen; k++) begin
      @(negedge clk);
      if (bus.mul_ready === 1'b1) begin
        seen   = 1'b1;
        at_cyc = cyc;
      end
    end
    check("ready_within_bound", 32'(seen), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},       32'(bus.ack), 32'd0);
    check({tag, "_busy"},      32'(bus.busy), 32'd0);
    check({tag, "_gnt_idx"},   32'(bus.gnt_idx), 32'd0);
    check({tag, "_res_out"},   bus.res_out, 32'd0);
    check({tag, "_err_out"},   32'(bus.err_out), 32'd0);
    check({tag, "_mul_ready"}, 32'(bus.mul_ready), 32'd0);
    check({tag, "_mul_op1"},   bus.mul_op1, 32'd0);
    check({tag, "_mul_op2"},   bus.mul_op2, 32'd0);
  endtask

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;
  vec_t vt[5];

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int t0, t1, prev;
    vt[0] = '{0, 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000};  // 3 * 2 = 6
    vt[1] = '{0, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000};  // 1.5 * 2 = 3
    vt[2] = '{1, 32'h4020_0000, 32'h4080_0000, 32'h4120_0000};  // 2.5 * 4 = 10
    vt[3] = '{2, 32'hBF80_0000, 32'h4040_0000, 32'hC040_0000};  // -1 * 3 = -3
    vt[4] = '{3, 32'h3F00_0000, 32'h3E80_0000, 32'h3E00_0000};  // 0.5 * 0.25 = 0.125

    // Round-robin: all four requesting from reset, distinct operands.
    bus.req     = '1;
    bus.op1_bus = '0;
    bus.op2_bus = '0;
    for (int k = 1; k < 5; k++) begin
      bus.op1_bus[vt[k].idx*32 +: 32] = vt[k].a;
      bus.op2_bus[vt[k].idx*32 +: 32] = vt[k].b;
    end
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    for (int k = 1; k < 5; k++) sb.push_back('{vt[k].idx, vt[k].res, 1'b0});
    sb.push_back('{vt[1].idx, vt[1].res, 1'b0});
    mul_lat = 1;
    rst     = 1'b1;
    prev    = -1;
    for (int k = 0; k < 5; k++) begin
      wait_ack(40, t1);
      if (k > 0) check("rr_ack_spacing", 32'(t1 - prev), 32'(mul_lat + 5));
      prev = t1;
    end
    bus.req = '0;
    @(negedge clk);
    check("rr_idle_after", 32'(bus.busy), 32'd0);

    // Table-driven single-requester transactions with varying multiplier latency.
    for (int k = 0; k < 5; k++) begin
      mul_lat = 1 + k;
      bus.op1_bus[vt[k].idx*32 +: 32] = vt[k].a;
      bus.op2_bus[vt[k].idx*32 +: 32] = vt[k].b;
      sb.push_back('{vt[k].idx, vt[k].res, 1'b0});
      bus.req = NREQ'(1 << vt[k].idx);
      wait_ack(40, t1);
      bus.req = '0;
      @(negedge clk);
      check("vec_idle_after", 32'(bus.busy), 32'd0);
    end

    // Requester 2 drops its request while the multiplier is working.
    mul_lat = 8;
    bus.op1_bus[2*32 +: 32] = 32'h4040_0000;
    bus.op2_bus[2*32 +: 32] = 32'h4040_0000;
    sb.push_back('{2, 32'h4110_0000, 1'b0});                     // 3 * 3 = 9
    bus.req = 4'b0100;
    wait_ready(20, t0);
    @(negedge clk);
    bus.req = '0;
    wait_ack(40, t1);
    repeat (4) @(negedge clk);
    check("drop_idle_after", 32'(bus.busy), 32'd0);

    // Operand bus changes after the grant must not reach the multiplier.
    mul_lat = 6;
    bus.op1_bus[31:0] = 32'h4040_0000;
    bus.op2_bus[31:0] = 32'h4080_0000;
    sb.push_back('{0, 32'h4140_0000, 1'b0});                     // 3 * 4 = 12
    bus.req = 4'b0001;
    wait_ready(20, t0);
    @(negedge clk);
    bus.op1_bus[31:0] = 32'h3F80_0000;
    bus.op2_bus[31:0] = 32'h3F80_0000;
    #1;
    check("hold_mul_op1", bus.mul_op1, 32'h4040_0000);
    check("hold_mul_op2", bus.mul_op2, 32'h4080_0000);
    wait_ack(40, t1);
    bus.req = '0;
    @(negedge clk);

    // Multiplier never answers: watchdog must expire after exactly TIMEOUT WAIT cycles.
    stub = 1'b1;
    bus.op1_bus[3*32 +: 32] = 32'h4000_0000;
    bus.op2_bus[3*32 +: 32] = 32'h4000_0000;
    sb.push_back('{3, 32'h7FFF_FFFF, 1'b1});
    bus.req = 4'b1000;
    wait_ready(20, t0);
    wait_ack(TIMEOUT + 20, t1);
    bus.req = '0;
    check("timeout_latency", 32'(t1 - t0), 32'(TIMEOUT + 1));
    @(negedge clk);
    check("timeout_idle_after", 32'(bus.busy), 32'd0);
    stub = 1'b0;

    // A done pulse outside WAIT is ignored and the last result holds.
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    @(negedge clk);
    check("stray_busy",     32'(bus.busy), 32'd0);
    check("stray_res_hold", bus.res_out, 32'h7FFF_FFFF);
    check("stray_err_hold", 32'(bus.err_out), 32'd1);

    // Reset in the middle of WAIT aborts the transaction with no ack.
    mul_lat = 20;
    bus.req = 4'b1000;
    wait_ready(20, t0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    bus.req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    mul_lat = 2;
    bus.op1_bus[1*32 +: 32] = 32'h40A0_0000;
    bus.op2_bus[1*32 +: 32] = 32'h3F00_0000;
    sb.push_back('{1, 32'h4020_0000, 1'b0});                     // 5 * 0.5 = 2.5
    bus.req = 4'b0010;
    wait_ack(40, t1);
    bus.req = '0;
    repeat (4) @(negedge clk);
    check("final_idle", 32'(bus.busy), 32'd0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_mul_arbiter.md
FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001 The block SHALL have the parameter NREQ, default 4, setting the number of requesters sharing one single-precision multiplier.
REQ-002 The block SHALL have the parameter TIMEOUT, default 64, setting the maximum number of WAIT cycles allowed for a multiplier done.
REQ-003 The block SHALL have the parameter IW, default 2, setting the grant index width, with 2^IW >= NREQ.
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have the port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have the port req, input, NREQ bits: per-requester level request.
REQ-007 The block SHALL have the port op1_bus, input, 32*NREQ bits: requester i first operand at bits [32i+31:32i].
REQ-008 The block SHALL have the port op2_bus, input, 32*NREQ bits: requester i second operand at bits [32i+31:32i].
REQ-009 The block SHALL have the port ack, output, NREQ bits: one-cycle completion pulse to the served requester.
REQ-010 The block SHALL have the port res_out, output, 32 bits: product for the acked requester.
REQ-011 The block SHALL have the port err_out, output, 1 bit: timeout flag qualifying res_out.
REQ-012 The block SHALL have the port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 The block SHALL have the port gnt_idx, output, IW bits: index of the current or last-served requester.
REQ-014 The block SHALL have the port mul_ready, output, 1 bit: start strobe to the multiplier.
REQ-015 The block SHALL have the port mul_op1, output, 32 bits: multiplier first operand.
REQ-016 The block SHALL have the port mul_op2, output, 32 bits: multiplier second operand.
REQ-017 The block SHALL have the port mul_res, input, 32 bits: multiplier result.
REQ-018 The block SHALL have the port mul_done, input, 1 bit: multiplier completion pulse.

Function
REQ-019 The controller SHALL be an FSM with the states IDLE, SETUP, ISSUE, WAIT and RESP.
REQ-020 In IDLE with any req bit set, the controller SHALL grant round-robin starting at last_grant+1 modulo NREQ, latch both operands of the winner into internal registers, set gnt_idx and go to SETUP.
REQ-021 In IDLE with req all-zero, the controller SHALL remain in IDLE.
REQ-022 In SETUP, mul_op1 and mul_op2 SHALL show the latched operands and mul_ready SHALL be 0 for exactly one cycle, so the multiplier samples its operands while in its start state; the controller then goes to ISSUE.
REQ-023 In ISSUE, mul_ready SHALL be 1 for exactly one cycle; the controller then goes to WAIT and clears the watchdog counter.
REQ-024 mul_op1 and mul_op2 SHALL be driven from the latched registers and stay constant from SETUP through RESP; requester bus changes after the grant SHALL have no effect.
REQ-025 In WAIT with mul_done sampled high, the controller SHALL capture mul_res into the result register, set err to 0 and go to RESP.
REQ-026 In WAIT without mul_done, the watchdog SHALL increment.
REQ-027 When the watchdog reaches TIMEOUT-1 with no mul_done, the controller SHALL load result 32'h7FFFFFFF, set err to 1 and go to RESP.
REQ-028 In RESP, ack[gnt_idx] SHALL be 1 for exactly one cycle, with res_out and err_out valid in the same cycle; last_grant SHALL take gnt_idx and the controller SHALL return to IDLE.
REQ-029 res_out and err_out SHALL hold their value until the next RESP.
REQ-030 A granted transaction SHALL complete and be acked even if its req bit drops before ack.
REQ-031 A requester holding req high after its ack SHALL be treated as a new request at lower round-robin priority than the other active requesters.
REQ-032 mul_done in any state other than WAIT SHALL be ignored.
REQ-033 req changes during busy SHALL be ignored until IDLE.
REQ-034 Minimum turnaround SHALL be IDLE→SETUP→ISSUE→WAIT, with ack one cycle after mul_done is sampled, and back-to-back grants SHALL have one IDLE cycle between them.
REQ-035 At most one ack bit SHALL be set in any cycle.

Reset
REQ-036 On rst low, the controller SHALL immediately, asynchronously, set state IDLE, ack 0, res_out 0, err_out 0, busy 0, gnt_idx 0, mul_ready 0, mul_op1 0, mul_op2 0 and watchdog 0.
REQ-037 On rst low, last_grant SHALL reset to NREQ-1 so requester 0 wins first.
REQ-038 A reset asserted mid-transaction SHALL abort it with no ack; the multiplier is reset by the same system reset.

Verification
REQ-039 The bench SHALL cover: req=0001 with op1 0x40400000 and op2 0x40000000, real multiplier -> one ack[0] pulse with res_out 0x40C00000 and err_out 0.
REQ-040 The bench SHALL cover: req=1111 held from reset with distinct operands -> acks in order 0,1,2,3,0; each res_out equals the product of its own operands.
REQ-041 The bench SHALL cover: requester 2 drops req in WAIT -> ack[2] still pulses with the correct product, and no other ack fires for that transaction.
REQ-042 The bench SHALL cover: stub multiplier that never asserts done -> ack after exactly TIMEOUT WAIT cycles with res_out 0x7FFFFFFF and err_out 1, then the controller returns to IDLE.
REQ-043 The bench SHALL cover: op1_bus changed during WAIT -> mul_op1 is unchanged and the result uses the latched operand.
REQ-044 The bench SHALL cover: rst low during WAIT -> all outputs are 0 in the same cycle, no ack fires, and after release req=0010 is served correctly.
